// File: rtl/write_back_stage_pkg.sv
// Shared widths and the branch-predictor training record carried through the
// write-back training FIFO.
package write_back_stage_pkg;

  localparam int WB_XLEN          = 32;
  localparam int WB_PC_WIDTH      = 32;
  localparam int WB_INSTR_WIDTH   = 32;
  localparam int WB_HISTORY_WIDTH = 8;

  typedef struct packed {
    logic [WB_PC_WIDTH-1:0]      pc;
    logic [WB_HISTORY_WIDTH-1:0] history;
    logic                        taken;
    logic                        predict;
    logic                        global_predict;
    logic                        local_predict;
    logic                        global_taken;
    logic                        local_taken;
    logic                        hit;
    logic                        jal;
  } train_rec_t;

  localparam int TRAIN_REC_W = WB_PC_WIDTH + WB_HISTORY_WIDTH + 8;

endpackage

// File: rtl/write_back_stage_train_fifo.sv
// Synchronous FIFO over packed training records; pointers wrap naturally
// because the depth is a power of two.
module wb_train_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the head is only meaningful when not empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/write_back_stage.sv
// Final pipeline stage: register-file write, retire accounting, commit trace
// and a buffered branch-predictor training port that back-pressures the pipe.
module write_back_stage
  import write_back_stage_pkg::*;
#(
  parameter int XLEN        = WB_XLEN,
  parameter int PC_WIDTH    = WB_PC_WIDTH,
  parameter int INSTR_WIDTH = WB_INSTR_WIDTH,
  parameter int HIST_W      = WB_HISTORY_WIDTH,
  parameter int TQ_DEPTH    = 4,
  parameter int CNT_W       = 64
) (
  input  logic                   clk_i,
  input  logic                   rst,
  input  logic                   memory_vaild_i,
  input  logic                   MD_sel_reg_i,
  input  logic [XLEN-1:0]        MD_valM_i,
  input  logic [XLEN-1:0]        MD_valE_i,
  input  logic                   MD_need_dstE_i,
  input  logic [4:0]             MD_dstE_i,
  input  logic [PC_WIDTH-1:0]    MD_PC_i,
  input  logic [PC_WIDTH-1:0]    MD_nPC_i,
  input  logic                   MD_commit_i,
  input  logic [INSTR_WIDTH-1:0] MD_instr_i,
  input  logic                   MD_train_vaild_i,
  input  logic                   MD_train_taken_i,
  input  logic                   MD_train_predict_i,
  input  logic [HIST_W-1:0]      MD_train_global_history_i,
  input  logic                   MD_train_global_predict_i,
  input  logic                   MD_train_local_predict_i,
  input  logic                   MD_train_global_taken_i,
  input  logic                   MD_train_local_taken_i,
  input  logic                   MD_success_hit_i,
  input  logic                   MD_jal_i,
  output logic                   write_back_allow_in_o,
  output logic                   W_we_o,
  output logic [4:0]             W_dst_o,
  output logic [XLEN-1:0]        W_val_o,
  output logic                   tr_valid_o,
  input  logic                   tr_ready_i,
  output logic [PC_WIDTH-1:0]    tr_pc_o,
  output logic [HIST_W-1:0]      tr_history_o,
  output logic                   tr_taken_o,
  output logic                   tr_predict_o,
  output logic                   tr_global_predict_o,
  output logic                   tr_local_predict_o,
  output logic                   tr_global_taken_o,
  output logic                   tr_local_taken_o,
  output logic                   tr_hit_o,
  output logic                   tr_jal_o,
  output logic [CNT_W-1:0]       instret_o,
  output logic [CNT_W-1:0]       br_cnt_o,
  output logic [CNT_W-1:0]       mispred_cnt_o,
  output logic                   cmt_valid_o,
  output logic [PC_WIDTH-1:0]    cmt_pc_o,
  output logic [PC_WIDTH-1:0]    cmt_npc_o,
  output logic [INSTR_WIDTH-1:0] cmt_instr_o
);

  localparam int CW = $clog2(TQ_DEPTH) + 1;

  logic             retire, push, pop, tq_empty;
  logic [CW-1:0]    tq_count;
  train_rec_t       rec_in, rec_out;

  logic [CNT_W-1:0]       instret_q, br_cnt_q, mispred_cnt_q;
  logic                   cmt_valid_q;
  logic [PC_WIDTH-1:0]    cmt_pc_q, cmt_npc_q;
  logic [INSTR_WIDTH-1:0] cmt_instr_q;

  // allow_in depends on occupancy only, so a same-cycle pop never reopens a full queue.
  assign write_back_allow_in_o = (tq_count != CW'(TQ_DEPTH));
  assign retire = memory_vaild_i && MD_commit_i && write_back_allow_in_o;
  assign push   = retire && MD_train_vaild_i;
  assign pop    = tr_valid_o && tr_ready_i;

  assign W_we_o  = retire && MD_need_dstE_i && (MD_dstE_i != 5'd0);
  assign W_dst_o = MD_dstE_i;
  assign W_val_o = MD_sel_reg_i ? MD_valM_i : MD_valE_i;

  assign rec_in = '{
    pc:             MD_PC_i,
    history:        MD_train_global_history_i,
    taken:          MD_train_taken_i,
    predict:        MD_train_predict_i,
    global_predict: MD_train_global_predict_i,
    local_predict:  MD_train_local_predict_i,
    global_taken:   MD_train_global_taken_i,
    local_taken:    MD_train_local_taken_i,
    hit:            MD_success_hit_i,
    jal:            MD_jal_i
  };

  wb_train_fifo #(
    .WIDTH (TRAIN_REC_W),
    .DEPTH (TQ_DEPTH)
  ) u_train_fifo (
    .clk_i   (clk_i),
    .rst     (rst),
    .push_i  (push),
    .data_i  (rec_in),
    .pop_i   (pop),
    .data_o  (rec_out),
    .count_o (tq_count),
    .empty_o (tq_empty)
  );

  assign tr_valid_o          = !tq_empty;
  assign tr_pc_o             = rec_out.pc;
  assign tr_history_o        = rec_out.history;
  assign tr_taken_o          = rec_out.taken;
  assign tr_predict_o        = rec_out.predict;
  assign tr_global_predict_o = rec_out.global_predict;
  assign tr_local_predict_o  = rec_out.local_predict;
  assign tr_global_taken_o   = rec_out.global_taken;
  assign tr_local_taken_o    = rec_out.local_taken;
  assign tr_hit_o            = rec_out.hit;
  assign tr_jal_o            = rec_out.jal;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      instret_q     <= '0;
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
      cmt_valid_q   <= 1'b0;
      cmt_pc_q      <= '0;
      cmt_npc_q     <= '0;
      cmt_instr_q   <= '0;
    end else begin
      cmt_valid_q <= retire;
      if (retire) begin
        instret_q   <= instret_q + CNT_W'(1);
        cmt_pc_q    <= MD_PC_i;
        cmt_npc_q   <= MD_nPC_i;
        cmt_instr_q <= MD_instr_i;
      end
      if (push) begin
        br_cnt_q <= br_cnt_q + CNT_W'(1);
        if (MD_train_predict_i != MD_train_taken_i)
          mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  assign instret_o     = instret_q;
  assign br_cnt_o      = br_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;
  assign cmt_valid_o   = cmt_valid_q;
  assign cmt_pc_o      = cmt_pc_q;
  assign cmt_npc_o     = cmt_npc_q;
  assign cmt_instr_o   = cmt_instr_q;

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
- Final pipeline stage. Consumes the memory→write-back register bundle (MD_* signals plus memory_vaild) and produces write_back_allow_in back toward the memory stage.
- Performs the architectural register-file write and retires instructions.
- Buffers branch-predictor training records in a small FIFO, so a busy predictor update port stalls the pipe instead of losing updates.
- Maintains retire and mispredict counters and a registered commit trace.

Parameters:
- XLEN, 32, data width.
- PC_WIDTH, 32, PC width.
- INSTR_WIDTH, 32, instruction width.
- HIST_W, 8, global-history width; must equal history_WIDTH.
- TQ_DEPTH, 4, training FIFO depth; power of two, ≥2.
- CNT_W, 64, performance counter width.

Ports:
- clk_i  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- memory_vaild_i  in  1  MD bundle holds a live instruction.
- MD_sel_reg_i  in  1  1 = write valM, 0 = write valE.
- MD_valM_i, MD_valE_i  in  XLEN  load data / ALU result.
- MD_need_dstE_i  in  1  instruction writes rd.
- MD_dstE_i  in  5  rd index.
- MD_PC_i, MD_nPC_i  in  PC_WIDTH  PC and resolved next PC.
- MD_commit_i  in  1  non-bubble marker.
- MD_instr_i  in  INSTR_WIDTH  instruction word.
- MD_train_vaild_i, MD_train_taken_i, MD_train_predict_i  in  1  branch-resolution record.
- MD_train_global_history_i  in  HIST_W  history at prediction time.
- MD_train_global_predict_i, MD_train_local_predict_i, MD_train_global_taken_i, MD_train_local_taken_i, MD_success_hit_i, MD_jal_i  in  1 each  predictor sub-component bits.
- write_back_allow_in_o  out  1  stage can accept the bundle this cycle.
- W_we_o  out  1  register-file write enable.
- W_dst_o  out  5  write index.
- W_val_o  out  XLEN  write data.
- tr_valid_o  out  1  FIFO head valid.
- tr_ready_i  in  1  predictor consumes the head.
- tr_pc_o  out  PC_WIDTH  head record field.
- tr_history_o  out  HIST_W  head record field.
- tr_taken_o, tr_predict_o, tr_global_predict_o, tr_local_predict_o, tr_global_taken_o, tr_local_taken_o, tr_hit_o, tr_jal_o  out  1 each  head record fields.
- instret_o  out  CNT_W  retired instructions.
- br_cnt_o  out  CNT_W  retired training records.
- mispred_cnt_o  out  CNT_W  retired mispredictions.
- cmt_valid_o  out  1  registered commit trace valid.
- cmt_pc_o  out  PC_WIDTH  trace PC.
- cmt_npc_o  out  PC_WIDTH  trace next PC.
- cmt_instr_o  out  INSTR_WIDTH  trace instruction.

Behaviour:
- On reset, asynchronously:
  - FIFO emptied (count = 0, read/write pointers = 0).
  - All counters = 0.
  - cmt_valid_o = 0, cmt_pc_o = 0, cmt_npc_o = 0, cmt_instr_o = 0.
  - Resulting outputs: tr_valid_o = 0, write_back_allow_in_o = 1, W_we_o = 0 while memory_vaild_i = 0.
- allow_in: write_back_allow_in_o = (count != TQ_DEPTH). It is combinational from state only, never from tr_ready_i. When the FIFO is full, allow_in stays 0 even in a cycle that pops.
- Retire: retire = memory_vaild_i & MD_commit_i & write_back_allow_in_o.
- Register write (combinational, committed by the register file at the next edge):
  - W_we_o = retire & MD_need_dstE_i & (MD_dstE_i != 0).
  - W_dst_o = MD_dstE_i.
  - W_val_o = MD_sel_reg_i ? MD_valM_i : MD_valE_i.
- Training FIFO:
  - push = retire & MD_train_vaild_i; pop = tr_valid_o & tr_ready_i.
  - A push writes all MD_train_* fields plus MD_PC_i, MD_success_hit_i and MD_jal_i.
  - Push and pop in the same cycle leave count unchanged. A pop on empty is impossible because tr_valid_o = 0.
  - Pointers wrap modulo TQ_DEPTH.
  - Head fields are driven from storage; their value when empty is don't-care.
- Counters (+1 at the edge, wrap modulo 2^CNT_W):
  - instret_o on retire.
  - br_cnt_o on push.
  - mispred_cnt_o on push & (MD_train_predict_i != MD_train_taken_i).
- Commit trace: each cycle, cmt_valid_o <= retire. On retire, cmt_pc/npc/instr load from the MD inputs; otherwise they hold.
- Bubbles (memory_vaild_i = 0, or MD_commit_i = 0): no write, no push, no count, cmt_valid_o = 0 next cycle.
- Latency: register write 0 cycles (same-cycle enable). Trace 1 cycle. Training head visible the cycle after push.

Decomposition:
- Shared package/define file:
  - XLEN, PC_WIDTH, INSTR_WIDTH, history_WIDTH.
  - Training-record field layout (packed width = PC_WIDTH + HIST_W + 8).
- One sub-module, wb_train_fifo: a synchronous FIFO over the packed record, providing count/full/empty and async reset.

Test Plan:
- Reset: assert rst mid-run with 3 entries queued → tr_valid_o = 0, counters = 0, allow_in = 1 immediately (asynchronously), cmt_valid_o = 0.
- Load retire: valid, commit, sel_reg = 1, valM = 0xDEADBEEF, valE = 0x10, dstE = 5, need = 1 → W_we_o = 1, W_dst_o = 5, W_val_o = 0xDEADBEEF; next cycle cmt_valid_o = 1, instret_o = 1.
- x0 suppression: dstE = 0, need = 1 → W_we_o = 0; instret_o still increments.
- Backpressure: tr_ready_i = 0, retire 4 branches → count = 4, allow_in = 0, and a 5th valid bundle produces no write or count. Then tr_ready_i = 1 for one cycle → allow_in = 0 that cycle, = 1 the next.
- Simultaneous push/pop at count = 2 → count stays 2; head order preserved (PCs 0x100, 0x104, 0x108 popped in order).
- Mispredict counting: 3 branches with predict/taken = 1/1, 0/1, 1/0 → br_cnt_o = 3, mispred_cnt_o = 2. A bubble with train_vaild = 1 but commit = 0 → no change.
